// File: rtl/gate_sequencer.sv
// gate_sequencer: barrier gate controller that tracks a car through beams A then B and pulses passed per traversal
// Ports: clock, reset (sync, active-high); req, permit (admission request/grant);
//        sens_a, sens_b (outer/inner beam blocked); gate_open, busy (state decode);
//        passed (one-cycle pulse per full traversal); aborted (one-cycle pulse on OPEN timeout).
// Optional feature: define GATE_TIMEOUT_EN to abort an opening left unused for TIMEOUT_CYCLES.
module gate_sequencer #(
    parameter int CLEAR_CYCLES   = 50_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic req,
    input  logic permit,
    input  logic sens_a,
    input  logic sens_b,
    output logic gate_open,
    output logic passed,
    output logic aborted,
    output logic busy
);
    localparam int MAXC = CLEAR_CYCLES > TIMEOUT_CYCLES ? CLEAR_CYCLES : TIMEOUT_CYCLES;
    localparam int W = $clog2(MAXC + 1);
    typedef enum logic [2:0] {IDLE, OPEN, A_ONLY, BOTH, B_ONLY, CLEAR} state_t;
    state_t state, nxt;
    logic [W-1:0] cnt;
    logic done, to;
    assign done = cnt == W'(CLEAR_CYCLES - 1);
`ifdef GATE_TIMEOUT_EN
    assign to = cnt == W'(TIMEOUT_CYCLES - 1);
`else
    assign to = 1'b0;
`endif
    assign gate_open = state != IDLE;
    assign busy = state != IDLE;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:   nxt = req && permit ? OPEN : IDLE;
            OPEN:   nxt = sens_a && !sens_b ? A_ONLY : to ? IDLE : OPEN;
            A_ONLY: nxt = sens_b ? BOTH : !sens_a ? OPEN : A_ONLY;
            BOTH:   nxt = !sens_a && sens_b ? B_ONLY : sens_a && !sens_b ? A_ONLY :
                          !sens_a && !sens_b ? OPEN : BOTH;
            B_ONLY: nxt = sens_a ? BOTH : !sens_b ? CLEAR : B_ONLY;
            // a following car takes over the open gate without a new request
            CLEAR:  nxt = sens_a ? A_ONLY : sens_b ? OPEN : done ? IDLE : CLEAR;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            passed <= 1'b0;
        end else begin
            state  <= nxt;
            // one shared counter serves both hold-off and timeout; it restarts on every state change
            cnt    <= nxt != state ? '0 : &cnt ? cnt : cnt + 1'b1;
            passed <= state == B_ONLY && nxt == CLEAR;
        end
    end
`ifdef GATE_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) aborted <= 1'b0;
        else aborted <= state == OPEN && nxt == IDLE;
    end
`else
    assign aborted = 1'b0;
`endif
endmodule

// File: tb/tb_gate_sequencer.sv
// tb_gate_sequencer: scenario bench for gate_sequencer with expected outputs queued per driven cycle
// Table entry layout: {reset, req, permit, sens_a, sens_b, gate_open, busy, passed, aborted}
module tb_gate_sequencer;
    logic clock = 1'b0;
    logic reset, req, permit, sens_a, sens_b;
    logic gate_open, passed, aborted, busy;
    int n_pass = 0;
    int n_total = 0;
    logic [3:0] exp_q[$];

    gate_sequencer #(.CLEAR_CYCLES(4), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset), .req(req), .permit(permit),
        .sens_a(sens_a), .sens_b(sens_b), .gate_open(gate_open),
        .passed(passed), .aborted(aborted), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic drive(input logic [8:0] e);
        {reset, req, permit, sens_a, sens_b} = e[8:4];
        exp_q.push_back(e[3:0]);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        logic [3:0] got, ev;
        drive(9'b1_0000_0000);
        drive(9'b1_1100_0000);
        got = {gate_open, busy, passed, aborted};
        ev = exp_q.pop_front();
        ev = exp_q.pop_front();
        n_total++;
        if (got !== ev) $display("FAIL reset got=%b exp=%b", got, ev);
        else n_pass++;
    endtask

    task automatic test_normal;
        logic [3:0] got, ev;
        logic [8:0] t[$] = '{
            9'b0_1100_1100, 9'b0_0010_1100, 9'b0_0010_1100, 9'b0_0011_1100,
            9'b0_0011_1100, 9'b0_0001_1100, 9'b0_0001_1100, 9'b0_0000_1110,
            9'b0_0000_1100, 9'b0_0000_1100, 9'b0_0000_1100, 9'b0_0000_0000,
            9'b0_0000_0000};
        foreach (t[i]) begin
            drive(t[i]);
            got = {gate_open, busy, passed, aborted};
            ev = exp_q.pop_front();
            n_total++;
            if (got !== ev) $display("FAIL normal[%0d] got=%b exp=%b", i, got, ev);
            else n_pass++;
        end
    endtask

    task automatic test_denied;
        logic [3:0] got, ev;
        for (int i = 0; i < 20; i++) begin
            drive(9'b0_1000_0000);
            got = {gate_open, busy, passed, aborted};
            ev = exp_q.pop_front();
            n_total++;
            if (got !== ev) $display("FAIL denied[%0d] got=%b exp=%b", i, got, ev);
            else n_pass++;
        end
    endtask

    task automatic test_back_out;
        logic [3:0] got, ev;
        logic [8:0] t[$] = '{
            9'b0_1100_1100, 9'b0_0010_1100, 9'b0_0000_1100, 9'b0_0010_1100,
            9'b0_0011_1100, 9'b0_0000_1100, 9'b0_0001_1100, 9'b0_0000_1100,
            9'b0_0010_1100, 9'b0_0011_1100, 9'b0_0001_1100, 9'b0_0000_1110,
            9'b0_0000_1100, 9'b0_0000_1100, 9'b0_0000_1100, 9'b0_0000_0000};
        foreach (t[i]) begin
            drive(t[i]);
            got = {gate_open, busy, passed, aborted};
            ev = exp_q.pop_front();
            n_total++;
            if (got !== ev) $display("FAIL back_out[%0d] got=%b exp=%b", i, got, ev);
            else n_pass++;
        end
    endtask

    task automatic test_tailgate;
        logic [3:0] got, ev;
        logic [8:0] t[$] = '{
            9'b0_1100_1100, 9'b0_0010_1100, 9'b0_0011_1100, 9'b0_0001_1100,
            9'b0_0000_1110, 9'b0_0000_1100, 9'b0_0010_1100, 9'b0_0011_1100,
            9'b0_0001_1100, 9'b0_0000_1110, 9'b0_0000_1100, 9'b0_0000_1100,
            9'b0_0000_1100, 9'b0_0000_0000};
        foreach (t[i]) begin
            drive(t[i]);
            got = {gate_open, busy, passed, aborted};
            ev = exp_q.pop_front();
            n_total++;
            if (got !== ev) $display("FAIL tailgate[%0d] got=%b exp=%b", i, got, ev);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] got, ev;
        logic [8:0] t[$] = '{
            9'b0_1100_1100, 9'b0_1110_1100, 9'b0_1011_1100, 9'b0_1001_1100,
            9'b0_1100_1110, 9'b0_1100_1100, 9'b0_1100_1100, 9'b0_1100_1100,
            9'b0_1100_0000, 9'b0_1100_1100, 9'b1_0000_0000};
        foreach (t[i]) begin
            drive(t[i]);
            got = {gate_open, busy, passed, aborted};
            ev = exp_q.pop_front();
            n_total++;
            if (got !== ev) $display("FAIL back_to_back[%0d] got=%b exp=%b", i, got, ev);
            else n_pass++;
        end
    endtask

    task automatic test_timeout;
        logic [3:0] got, ev;
        logic [8:0] t[$];
        t.push_back(9'b0_1100_1100);
`ifdef GATE_TIMEOUT_EN
        for (int i = 0; i < 7; i++) t.push_back(9'b0_0000_1100);
        t.push_back(9'b0_0000_0001);
        t.push_back(9'b0_0000_0000);
`else
        for (int i = 0; i < 100; i++) t.push_back(9'b0_0000_1100);
        t.push_back(9'b1_0000_0000);
`endif
        foreach (t[i]) begin
            drive(t[i]);
            got = {gate_open, busy, passed, aborted};
            ev = exp_q.pop_front();
            n_total++;
            if (got !== ev) $display("FAIL timeout[%0d] got=%b exp=%b", i, got, ev);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_both;
        logic [3:0] got, ev;
        logic [8:0] t[$] = '{
            9'b0_1100_1100, 9'b0_0010_1100, 9'b0_0011_1100, 9'b1_0011_0000,
            9'b0_0011_0000, 9'b0_0001_0000, 9'b0_0000_0000, 9'b0_0000_0000};
        foreach (t[i]) begin
            drive(t[i]);
            got = {gate_open, busy, passed, aborted};
            ev = exp_q.pop_front();
            n_total++;
            if (got !== ev) $display("FAIL reset_mid_both[%0d] got=%b exp=%b", i, got, ev);
            else n_pass++;
        end
    endtask

    initial begin
        {reset, req, permit, sens_a, sens_b} = 5'b10000;
        test_reset();
        test_normal();
        test_denied();
        test_back_out();
        test_tailgate();
        test_back_to_back();
        test_timeout();
        test_reset_mid_both();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
